// File: rtl/alu_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_add_seq (+ csa_16_bits)                                       |
// | Desc   : Slice-serial W-bit add/subtract on one shared 16-bit adder.       |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module csa_16_bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [4:0] w_c;

    assign w_c[0] = c_in;

    // Four 4-bit carry-select blocks: both carry hypotheses precomputed, muxed by the incoming carry
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [4:0] w_s0;
        logic [4:0] w_s1;

        assign w_s0             = {1'b0, a[g*4 +: 4]} + {1'b0, b[g*4 +: 4]};
        assign w_s1             = w_s0 + 5'd1;
        assign sum[g*4 +: 4]    = w_c[g] ? w_s1[3:0] : w_s0[3:0];
        assign w_c[g+1]         = w_c[g] ? w_s1[4]   : w_s0[4];
    end

    assign c_out = w_c[4];
endmodule

module alu_add_seq #(
    parameter int NSLICE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [16*NSLICE-1:0]   op_a,
    input  logic [16*NSLICE-1:0]   op_b,
    input  logic                   sub,
    input  logic                   c_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [16*NSLICE-1:0]   result,
    output logic                   carry,
    output logic                   ovf,
    output logic                   zero
);
    localparam int c_W  = 16 * NSLICE;
    localparam int c_IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_W-1:0]    r_a;
    logic [c_W-1:0]    r_b;
    logic [c_W-1:0]    r_result;
    logic [c_W-1:0]    w_result_nxt;
    logic [c_IW-1:0]   r_idx;
    logic              r_cy;
    logic              r_carry;
    logic              r_ovf;
    logic              r_zero;
    logic [15:0]       w_sum;
    logic              w_cout;
    logic              w_last;
    logic              w_ovf_nxt;

    csa_16_bits u_csa (
        .a     (r_a[r_idx*16 +: 16]),
        .b     (r_b[r_idx*16 +: 16]),
        .c_in  (r_cy),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    assign w_last = (r_idx == c_IW'(NSLICE - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_state_nxt = CALC;
            CALC:    if (w_last)      w_state_nxt = DONE;
            DONE:    if (res_ready)   w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Result image including the slice being produced this cycle; flags on DONE entry come from it
    always_comb begin
        w_result_nxt                  = r_result;
        w_result_nxt[r_idx*16 +: 16]  = w_sum;
        w_ovf_nxt = (r_a[c_W-1] == r_b[c_W-1]) && (w_result_nxt[c_W-1] != r_a[c_W-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_cy     <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_a   <= op_a;
                        r_b   <= op_b ^ {c_W{sub}};
                        r_idx <= '0;
                        r_cy  <= sub ? 1'b1 : c_in;
                    end
                end
                CALC: begin
                    r_result <= w_result_nxt;
                    r_cy     <= w_cout;
                    if (w_last) begin
                        r_carry <= w_cout;
                        r_ovf   <= w_ovf_nxt;
                        r_zero  <= (w_result_nxt == '0);
                    end else begin
                        r_idx <= r_idx + c_IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (r_state == IDLE) && rst_n;
    assign res_valid   = (r_state == DONE);
    assign result      = r_result;
    assign carry       = r_carry;
    assign ovf         = r_ovf;
    assign zero        = r_zero;
endmodule

`default_nettype wire

// File: tb/tb_alu_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_alu_add_seq                                                    |
// | Desc   : Directed + random bench for alu_add_seq against an arithmetic model|
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module tb_alu_add_seq;
    localparam int NSLICE = 4;
    localparam int W      = 16 * NSLICE;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          sub;
    logic          c_in;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  result;
    logic          carry;
    logic          ovf;
    logic          zero;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] last_res;
    logic         last_c;
    logic         last_o;
    logic         last_z;

    alu_add_seq #(.NSLICE(NSLICE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .sub         (sub),
        .c_in        (c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry       (carry),
        .ovf         (ovf),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: true integer arithmetic, not the slice datapath
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic ci, output logic [W-1:0] r, output logic c,
                         output logic o, output logic z);
        logic signed [W+1:0] sv;
        logic [W:0]          us;
        if (s) begin
            sv = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
            c  = (a >= b);
        end else begin
            sv = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + (ci ? 1 : 0);
            us = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            c  = us[W];
        end
        r = sv[W-1:0];
        o = (sv[W] != sv[W-1]);
        z = (r == '0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic ci, input int hold, input string tag);
        logic [W-1:0] er;
        logic         ec, eo, ez;
        int           lat;
        model(a, b, s, ci, er, ec, eo, ez);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; c_in = ci; start_valid = 1'b1;
        #1;
        check({tag, "_ready"}, W'(start_ready), W'(1));
        @(posedge clk);
        lat = 1;
        #1;
        start_valid = 1'b0;
        op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
        sub = ~s; c_in = ~ci;
        @(negedge clk);
        check({tag, "_calc_ready"}, W'(start_ready), W'(0));
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, W'(lat), W'(NSLICE + 1));
        check({tag, "_res"}, result, er);
        check({tag, "_flags"}, W'({carry, ovf, zero}), W'({ec, eo, ez}));
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold"}, W'({res_valid, start_ready, carry, ovf, zero}),
                  W'({1'b1, 1'b0, ec, eo, ez}));
            check({tag, "_hold_res"}, result, er);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_idle"}, W'({res_valid, start_ready}), W'({1'b0, 1'b1}));
        check({tag, "_retain"}, result, er);
        last_res = result; last_c = carry; last_o = ovf; last_z = zero;
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", W'({res_valid, start_ready, carry, ovf, zero}), W'(0));
        check("rst_res", result, W'(0));
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", W'(start_ready), W'(1));

        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, "add_ffff");
        check("add_ffff_const", last_res, 64'h0000_0000_0001_0000);
        check("add_ffff_fl", W'({last_c, last_o, last_z}), W'(3'b000));

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, "add_wrap");
        check("add_wrap_const", last_res, W'(0));
        check("add_wrap_fl", W'({last_c, last_o, last_z}), W'(3'b101));

        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0, "sub_ovf");
        check("sub_ovf_const", last_res, 64'h8000_0000_0000_0000);
        check("sub_ovf_fl", W'({last_c, last_o, last_z}), W'(3'b010));

        do_op(64'h5, 64'h5, 1'b1, 1'b0, 0, "sub_eq");
        check("sub_eq_const", last_res, W'(0));
        check("sub_eq_fl", W'({last_c, last_o, last_z}), W'(3'b101));

        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, 10, "hold10");

        // Abort mid-computation: two slices done, then a one-cycle reset
        @(negedge clk);
        op_a = 64'hAAAA_BBBB_CCCC_DDDD; op_b = 64'h1111_2222_3333_4444;
        sub = 1'b0; c_in = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_state", W'({res_valid, start_ready, carry, ovf, zero}), W'(5'b01000));
        check("abort_res", result, W'(0));
        do_op(64'h1, 64'h1, 1'b0, 1'b0, 0, "post_abort");
        check("post_abort_const", last_res, W'(2));

        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k % 6 == 0) rb = ~ra;
            if (k % 6 == 1) rb = ra;
            do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alu_add_seq.md
ALU_ADD_SEQ -- requirements
Module: alu_add_seq

Interface
REQ-001 Parameter NSLICE, default 4, number of 16-bit slices; operand width W = 16*NSLICE.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start_valid  input  1  requester presents an operation.
REQ-005 start_ready  output  1  block can accept an operation.
REQ-006 op_a  input  W  first operand.
REQ-007 op_b  input  W  second operand.
REQ-008 sub  input  1  0: a+b+c_in; 1: a-b, i.e. a + ~b + 1.
REQ-009 c_in  input  1  carry-in for add; ignored when sub=1.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 result  output  W  sum/difference, registered.
REQ-013 carry  output  1  final carry-out; for sub, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  result == 0.

Function
REQ-016 Block SHALL compute the W-bit operation serially on one shared instance of csa_16_bits, one 16-bit slice per cycle, LSB slice first.
REQ-017 FSM SHALL have states IDLE, CALC, DONE; start_ready = 1 only in IDLE with rst_n high; res_valid = 1 only in DONE.
REQ-018 IDLE: on start_valid && start_ready, SHALL latch op_a, op_b ^ {W{sub}}, sub; set slice index 0; set carry register to (sub ? 1 : c_in); go to CALC.
REQ-019 CALC: each cycle SHALL feed slice[idx] of latched a and b', plus carry register, to the adder; write its sum into result slice[idx]; load carry register with adder c_out; increment idx.
REQ-020 CALC SHALL exit to DONE after slice NSLICE-1 is written; idx SHALL not wrap.
REQ-021 Latency: accept edge at cycle T -> res_valid high from cycle T+NSLICE+1 (T+5 for NSLICE=4).
REQ-022 carry SHALL equal c_out of the top slice; ovf SHALL be (a[W-1] == b'[W-1]) && (result[W-1] != a[W-1]); zero SHALL be (result == 0); all set on entry to DONE.
REQ-023 DONE: result, carry, ovf, zero SHALL hold stable while res_ready is low; on res_valid && res_ready, go to IDLE next cycle and deassert res_valid.
REQ-024 No back-to-back acceptance: start_ready SHALL be 0 in CALC and DONE, and start_valid there SHALL be ignored with no state change.
REQ-025 Changes on op_a/op_b/sub/c_in after acceptance SHALL not affect the in-flight result.
REQ-026 result/flags SHALL retain the last completed values in IDLE until the next operation's DONE entry; partial slice writes in CALC are not observable as valid.

Reset
REQ-027 rst_n low at a clock edge SHALL force state IDLE, idx 0, carry register 0, result 0, carry 0, ovf 0, zero 0, res_valid 0.
REQ-028 Reset in CALC or DONE SHALL abort the operation with no result delivered; start_ready SHALL be 1 on the first cycle after rst_n returns high.

Verification
REQ-029 Add 0x0000_0000_0000_FFFF + 0x1, c_in=0 -> result 0x0000_0000_0001_0000, carry 0, ovf 0, zero 0, res_valid exactly 5 cycles after accept.
REQ-030 Add 0xFFFF_FFFF_FFFF_FFFF + 0x1, c_in=0 -> result 0, carry 1, ovf 0, zero 1.
REQ-031 Sub 0x7FFF_FFFF_FFFF_FFFF - 0xFFFF_FFFF_FFFF_FFFF -> result 0x8000_0000_0000_0000, carry 0, ovf 1, zero 0.
REQ-032 Sub 0x5 - 0x5 with c_in=0 -> result 0, carry 1, ovf 0, zero 1 (c_in ignored).
REQ-033 Hold res_ready=0 for 10 cycles in DONE while pulsing start_valid with new operands -> result/flags unchanged, start_ready 0, no new operation; res_ready=1 -> IDLE next cycle.
REQ-034 Assert rst_n=0 for one cycle after 2 slices of CALC -> next cycle state IDLE, res_valid 0, result 0, start_ready 1; following add 0x1+0x1 -> result 0x2.
